// File: rtl/muller_c_pkg.sv
// Shared types and constants for the Muller C-element sequencer.
package muller_c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    RISE,
    FALL,
    HOLD,
    DONE
  } state_e;

  localparam logic OP_CYCLE = 1'b0;
  localparam logic OP_HOLD  = 1'b1;

endpackage

// File: rtl/mc_sync.sv
// Multi-flop synchronizer for the asynchronous C-element output.
module mc_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/muller_c_seq_ctrl.sv
// Round-robin sequencer sharing one C-element test cell between NREQ requesters;
// runs a rise/fall cycle or a hold check and reports ack/err per operation.
module muller_c_seq_ctrl
  import muller_c_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TMO_W       = 8,
  parameter int unsigned HOLD_CYC    = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_op,
  output logic [NREQ-1:0] o_ack,
  output logic            o_err,
  output logic            o_busy,
  output logic            o_fault,
  output logic            o_c_a,
  output logic            o_c_b,
  input  logic            i_c_out
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  state_e            r_state;
  logic [IDX_W-1:0]  r_gnt;
  logic [IDX_W-1:0]  r_rr;
  logic              r_op;
  logic              r_err_q;
  logic [TMO_W-1:0]  r_cnt;
  logic [NREQ-1:0]   r_ack;
  logic              r_err;
  logic              r_busy;
  logic              r_fault;
  logic              r_c_a;
  logic              r_c_b;

  logic              w_c_sync;
  logic              w_tmo;
  logic [IDX_W-1:0]  w_pick;
  logic [IDX_W-1:0]  w_rr_next;
  logic [NREQ-1:0]   w_gnt_oh;

  // First set request at or after ptr, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  mc_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_c_out),
    .o_q    (w_c_sync)
  );

  assign w_tmo     = &r_cnt;
  assign w_pick    = rr_pick(i_req, r_rr);
  assign w_rr_next = (r_gnt == IDX_W'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
  assign w_gnt_oh  = {{(NREQ-1){1'b0}}, 1'b1} << r_gnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_rr    <= '0;
      r_op    <= OP_CYCLE;
      r_err_q <= 1'b0;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
      r_c_a   <= 1'b0;
      r_c_b   <= 1'b0;
    end else begin
      r_ack <= '0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|i_req) begin
            r_gnt   <= w_pick;
            r_op    <= i_op[w_pick];
            r_busy  <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          r_cnt <= '0;
          r_c_a <= 1'b1;
          if (r_op == OP_HOLD) begin
            r_c_b   <= 1'b0;
            r_state <= HOLD;
          end else begin
            r_c_b   <= 1'b1;
            r_state <= RISE;
          end
        end
        RISE: begin
          if (w_c_sync || w_tmo) begin
            if (!w_c_sync) r_err_q <= 1'b1;
            r_c_a   <= 1'b0;
            r_c_b   <= 1'b0;
            r_cnt   <= '0;
            r_state <= FALL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FALL: begin
          if (!w_c_sync) begin
            r_ack   <= w_gnt_oh;
            r_err   <= r_err_q;
            r_state <= DONE;
          end else if (w_tmo) begin
            // Cell stuck high: report and latch the fault, but keep serving.
            r_ack   <= w_gnt_oh;
            r_err   <= 1'b1;
            r_err_q <= 1'b1;
            r_fault <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (w_c_sync) r_err_q <= 1'b1;
          if (r_cnt == TMO_W'(HOLD_CYC - 1)) begin
            r_c_a   <= 1'b0;
            r_c_b   <= 1'b0;
            r_cnt   <= '0;
            r_state <= FALL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_rr    <= w_rr_next;
          r_err_q <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ack   = r_ack;
  assign o_err   = r_err;
  assign o_busy  = r_busy;
  assign o_fault = r_fault;
  assign o_c_a   = r_c_a;
  assign o_c_b   = r_c_b;

endmodule

// File: tb/tb_muller_c_seq_ctrl.sv
// Self-checking bench: cell model, per-cycle timeline model and directed scenarios.
module tb_muller_c_seq_ctrl;

  localparam int N = 4;
  localparam int S = 2;
  localparam int W = 8;
  localparam int H = 16;
  localparam int T = 1 << W;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = 4'b0;
  logic [3:0] op    = 4'b0;
  logic [3:0] ack;
  logic       err, busy, fault, c_a, c_b;
  logic       c_out;
  int         cell_mode = 0;  // 0 good, 1 stuck 0, 2 stuck 1, 3 follows a only

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hold_cnt = 0;

  always #5 clk = ~clk;

  muller_c_seq_ctrl #(
    .NREQ       (N),
    .SYNC_STAGES(S),
    .TMO_W      (W),
    .HOLD_CYC   (H)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_req  (req),
    .i_op   (op),
    .o_ack  (ack),
    .o_err  (err),
    .o_busy (busy),
    .o_fault(fault),
    .o_c_a  (c_a),
    .o_c_b  (c_b),
    .i_c_out(c_out)
  );

  // C-element cell: follows a when a==b, otherwise holds.
  always @(c_a or c_b or cell_mode) begin
    case (cell_mode)
      1: c_out = 1'b0;
      2: c_out = 1'b1;
      3: c_out = c_a;
      default: if (c_a == c_b) c_out = c_a;
    endcase
  end

  // Model: an operation is a timeline from its grant edge: phase 1 (L1 cycles),
  // phase 2 (L2 cycles), one ack cycle, one idle cycle.
  logic       m_act = 1'b0;
  int         m_t0, m_l1, m_l2, m_g, m_rr = 0;
  logic       m_op, m_err, m_flt, m_fault = 1'b0;
  logic [3:0] exp_ack = '0;
  logic       exp_err = 1'b0, exp_busy = 1'b0, exp_fault = 1'b0, exp_ca = 1'b0, exp_cb = 1'b0;

  task automatic plan(input logic o, input int cm, output int l1, output int l2,
                      output logic e, output logic f);
    if (!o) begin
      case (cm)
        1:       begin l1 = T;     l2 = 1;     e = 1'b1; f = 1'b0; end
        2:       begin l1 = 1;     l2 = T;     e = 1'b1; f = 1'b1; end
        default: begin l1 = S + 1; l2 = S + 1; e = 1'b0; f = 1'b0; end
      endcase
    end else begin
      case (cm)
        2:       begin l1 = H; l2 = T;     e = 1'b1; f = 1'b1; end
        3:       begin l1 = H; l2 = S + 1; e = 1'b1; f = 1'b0; end
        default: begin l1 = H; l2 = 1;     e = 1'b0; f = 1'b0; end
      endcase
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    int k, d;
    if (!rst_n) begin
      m_act = 1'b0; m_rr = 0; m_fault = 1'b0;
      exp_ack = '0; exp_err = 1'b0; exp_busy = 1'b0; exp_fault = 1'b0;
      exp_ca = 1'b0; exp_cb = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (!m_act && req != 4'b0) begin
        m_g = -1;
        for (int i = 0; i < N; i++)
          if (m_g < 0 && req[(m_rr + i) % N]) m_g = (m_rr + i) % N;
        m_op = op[m_g];
        plan(m_op, cell_mode, m_l1, m_l2, m_err, m_flt);
        m_t0  = cyc;
        m_act = 1'b1;
      end
      if (m_act) begin
        k = cyc - m_t0;
        d = m_l1 + m_l2 + 1;
        exp_busy = (k <= d);
        exp_ca   = (k >= 1) && (k <= m_l1);
        exp_cb   = exp_ca && !m_op;
        exp_ack  = (k == d) ? (4'(1) << m_g) : 4'b0;
        exp_err  = (k == d) && m_err;
        if (k == d) begin
          if (m_flt) m_fault = 1'b1;
          m_rr = (m_g + 1) % N;
        end
        if (k == d + 1) m_act = 1'b0;
      end else begin
        exp_ack = '0; exp_err = 1'b0; exp_busy = 1'b0; exp_ca = 1'b0; exp_cb = 1'b0;
      end
      exp_fault = m_fault;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      total = total + 1;
      if ({ack, err, busy, fault, c_a, c_b} !== {exp_ack, exp_err, exp_busy, exp_fault, exp_ca, exp_cb}) begin
        bad = bad + 1;
        $display("FAIL cycle_model cyc=%0d got ack=%b err=%b busy=%b fault=%b ca=%b cb=%b want ack=%b err=%b busy=%b fault=%b ca=%b cb=%b",
                 cyc, ack, err, busy, fault, c_a, c_b,
                 exp_ack, exp_err, exp_busy, exp_fault, exp_ca, exp_cb);
      end
      if (c_a && !c_b) hold_cnt = hold_cnt + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic wait_ack(input string nm, output int at, output logic [3:0] a, output logic e);
    at = -1; a = '0; e = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ack != 4'b0) begin
        at = cyc; a = ack; e = err;
        break;
      end
    end
    if (at < 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL %s ack_timeout got=none want=ack", nm);
    end
  endtask

  task automatic run_op(input logic [3:0] r, input logic [3:0] o, input int lat,
                        input logic [3:0] want_ack, input logic want_err, input string nm);
    int c0, at;
    logic [3:0] a;
    logic e;
    @(negedge clk);
    req = r; op = o; c0 = cyc;
    wait_ack(nm, at, a, e);
    req = '0; op = '0;
    if (at >= 0) begin
      check({nm, "_lat"}, at - (c0 + 1), lat);
      check({nm, "_ack"}, a, want_ack);
      check({nm, "_err"}, e, want_err);
    end
    repeat (4) @(negedge clk);
  endtask

  int         ord_exp[5] = '{0, 1, 2, 3, 0};
  int         t_ack[5];

  initial begin
    int at, idx;
    logic [3:0] a;
    logic e;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_cab", {c_a, c_b}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All requesters held: round-robin order, 9-cycle period (1 idle between ops)
    req = 4'hF; op = 4'h0;
    for (int n = 0; n < 5; n++) begin
      wait_ack("rr", at, a, e);
      t_ack[n] = at;
      idx = -1;
      for (int b = 0; b < N; b++) if (a[b]) idx = b;
      check("rr_order", idx, ord_exp[n]);
      if (n > 0) check("rr_period", t_ack[n] - t_ack[n-1], 9);
    end
    req = '0;
    repeat (4) @(negedge clk);

    run_op(4'b0001, 4'b0000, 7, 4'b0001, 1'b0, "t1_cycle");

    cell_mode = 1;
    repeat (4) @(negedge clk);
    run_op(4'b0010, 4'b0000, 258, 4'b0010, 1'b1, "t3_stuck0");
    check("t3_fault", fault, 0);

    cell_mode = 2;
    repeat (4) @(negedge clk);
    run_op(4'b0100, 4'b0000, 258, 4'b0100, 1'b1, "t4_stuck1");
    check("t4_fault", fault, 1);
    cell_mode = 0;
    repeat (4) @(negedge clk);

    hold_cnt = 0;
    run_op(4'b1000, 4'b1000, 18, 4'b1000, 1'b0, "t5_hold_ok");
    check("t5_hold_cycles", hold_cnt, 16);

    cell_mode = 3;
    run_op(4'b0001, 4'b0001, 20, 4'b0001, 1'b1, "t5_hold_bad");
    cell_mode = 0;
    check("t5_fault_sticky", fault, 1);

    // Leave rr_ptr at 2, then reset during RISE of requester 3
    run_op(4'b0010, 4'b0000, 7, 4'b0010, 1'b0, "t6_pre");
    @(negedge clk);
    req = 4'b1000; op = 4'b0000;
    repeat (2) @(negedge clk);
    check("t6_in_rise", {c_a, c_b}, 3);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_cab", {c_a, c_b}, 0);
    check("t6_rst_ack", ack, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_fault", fault, 0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_op(4'b0101, 4'b0000, 7, 4'b0001, 1'b0, "t6_rr0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
